pdh_demodulator: RTL and testbench

Lock-in demodulator for the PDH error signal. It multiplies each photodetector ADC sample by ±1, with the sign taken from the PDH square-wave reference lanes that the phase generator produces. It then integrates and dumps over 2^k valid samples and emits a scaled, signed error word for the lock servo. It sits between the phase generator's `pdh_output` lanes / ADC capture path and the downstream loop filter.

---
 rtl/pdh_demodulator.sv | 144 ++++++++++++++
 tb/tb_pdh_demodulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pdh_demodulator.sv
// pdh_demodulator: lock-in PDH demodulator with ±1 mixing, integrate-and-dump over 2^k samples.
// Optional PDH_DEMOD_SAT_EN: saturating err and sticky ovf; otherwise err wraps and ovf is 0.
module pdh_demodulator #(
    parameter int ADC_WIDTH     = 16,
    parameter int OUT_WIDTH     = 16,
    parameter int MAX_DEC_LOG2  = 12,
    parameter int MAX_REF_DELAY = 15
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic signed [ADC_WIDTH-1:0] adc,
    input  logic                        adc_valid,
    input  logic [7:0]                  pdh_ref,
    input  logic [2:0]                  ref_sel,
    input  logic [3:0]                  ref_delay,
    input  logic                        invert,
    input  logic [3:0]                  dec_log2,
    input  logic [2:0]                  gain_log2,
    input  logic                        clr,
    output logic signed [OUT_WIDTH-1:0] err,
    output logic                        err_valid,
    output logic                        ovf
);
    localparam int PW = ADC_WIDTH + 1;
    localparam int AW = PW + MAX_DEC_LOG2;
    localparam int CW = MAX_DEC_LOG2;
    localparam int YW = AW + 7;

    logic [MAX_REF_DELAY:1] dly;
    logic [MAX_REF_DELAY:0] taps;
    logic                   ref_bit;
    logic signed [PW-1:0]   p;
    logic                   p_vld;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   dump;
    logic                   dump_vld;
    logic [CW-1:0]          cnt;
    logic [3:0]             k_in;
    logic [3:0]             k_win;
    logic [3:0]             k_eff;
    logic [3:0]             dump_k;
    logic                   last;
    logic                   y_vld;

    // tap 0 is the live lane, tap d is the lane as sampled d edges ago
    assign taps    = {dly, pdh_ref[ref_sel]};
    assign ref_bit = taps[ref_delay];
    assign k_in    = (dec_log2 > 4'(MAX_DEC_LOG2)) ? 4'(MAX_DEC_LOG2) : dec_log2;
    assign k_eff   = (cnt == '0) ? k_in : k_win;
    assign last    = {1'b0, cnt} == ((CW+1)'(1) << k_eff) - (CW+1)'(1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            dly <= '0;
        else
            dly <= {dly[MAX_REF_DELAY-1:1], taps[0]};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            p     <= '0;
            p_vld <= 1'b0;
        end else begin
            p_vld <= adc_valid && !clr;
            if (adc_valid && !clr)
                p <= (ref_bit ^ invert) ? PW'(adc) : -PW'(adc);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            acc      <= '0;
            cnt      <= '0;
            dump     <= '0;
            dump_vld <= 1'b0;
            k_win    <= '0;
            dump_k   <= '0;
        end else if (clr) begin
            acc      <= '0;
            cnt      <= '0;
            dump_vld <= 1'b0;
        end else begin
            dump_vld <= p_vld && last;
            if (p_vld) begin
                k_win <= k_eff;
                if (last) begin
                    dump   <= acc + AW'(p);
                    dump_k <= k_eff;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    acc <= acc + AW'(p);
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

`ifdef PDH_DEMOD_SAT_EN
    logic signed [YW-1:0] y_r;
    logic                 over;
    logic                 under;

    assign over  = y_r > YW'((1 << (OUT_WIDTH-1)) - 1);
    assign under = y_r < -YW'(1 << (OUT_WIDTH-1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            y_r       <= '0;
            y_vld     <= 1'b0;
            err       <= '0;
            err_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            y_vld     <= dump_vld && !clr;
            y_r       <= (YW'(dump) >>> dump_k) <<< gain_log2;
            err_valid <= y_vld && !clr;
            if (y_vld && !clr)
                err <= over ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : under ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : y_r[OUT_WIDTH-1:0];
            ovf       <= !clr && (ovf || (y_vld && (over || under)));
        end
    end
`else
    logic [OUT_WIDTH-1:0] y_r;

    assign ovf = 1'b0;

    // only the low OUT_WIDTH bits survive wrapping, so the shift can run narrow
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            y_r       <= '0;
            y_vld     <= 1'b0;
            err       <= '0;
            err_valid <= 1'b0;
        end else begin
            y_vld     <= dump_vld && !clr;
            y_r       <= OUT_WIDTH'(dump >>> dump_k) << gain_log2;
            err_valid <= y_vld && !clr;
            if (y_vld && !clr)
                err <= y_r;
        end
    end
`endif
endmodule

// File: tb/tb_pdh_demodulator.sv
// tb_pdh_demodulator: directed vector table plus hand-written multi-cycle sequences.
module tb_pdh_demodulator;
    logic               sys_clk = 1'b0;
    logic               sys_rst = 1'b1;
    logic signed [15:0] adc = '0;
    logic               adc_valid = 1'b0;
    logic [7:0]         pdh_ref = '0;
    logic [2:0]         ref_sel = '0;
    logic [3:0]         ref_delay = '0;
    logic               invert = 1'b0;
    logic [3:0]         dec_log2 = '0;
    logic [2:0]         gain_log2 = '0;
    logic               clr = 1'b0;
    logic signed [15:0] err;
    logic               err_valid;
    logic               ovf;

    int tests = 0;
    int fails = 0;
    bit ph = 1'b0;
    bit alt = 1'b0;

`ifdef PDH_DEMOD_SAT_EN
    localparam int E_NEG = 32767;
    localparam int E_BIG = 32767;
    localparam int O_SAT = 1;
`else
    localparam int E_NEG = -32768;
    localparam int E_BIG = -11072;
    localparam int O_SAT = 0;
`endif

    typedef struct {
        logic signed [15:0] adc;
        logic [7:0]         pref;
        logic [2:0]         sel;
        logic               inv;
        logic [3:0]         dec;
        logic [2:0]         gain;
        int                 exp_err;
        int                 exp_ovf;
        int                 n;
    } vec_t;

    vec_t vecs[10];

    pdh_demodulator dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .adc(adc), .adc_valid(adc_valid),
        .pdh_ref(pdh_ref), .ref_sel(ref_sel), .ref_delay(ref_delay), .invert(invert),
        .dec_log2(dec_log2), .gain_log2(gain_log2), .clr(clr),
        .err(err), .err_valid(err_valid), .ovf(ovf)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_strobe(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (err_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic tog_tick();
        ph = ~ph;
        pdh_ref = {8{ph}};
        adc = alt ? (ph ? 16'sd300 : -16'sd300) : 16'sd300;
        tick();
    endtask

    task automatic tog_mode(input bit a, input logic [3:0] d, input int exp, input string name);
        int seen;
        seen = 0;
        alt = a;
        ref_delay = d;
        clr = 1'b1;
        tog_tick();
        clr = 1'b0;
        adc_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tog_tick();
            if (err_valid) begin
                seen++;
                check({name, " err"}, err, exp);
            end
        end
        check({name, " strobes"}, seen, 4);
        adc_valid = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        vecs[0] = '{16'sd1000,   8'hFF, 3'd0, 1'b0, 4'd4,  3'd0, 1000,  0,     16};
        vecs[1] = '{16'sd1000,   8'hFF, 3'd0, 1'b1, 4'd4,  3'd0, -1000, 0,     16};
        vecs[2] = '{-16'sd32768, 8'hFF, 3'd0, 1'b1, 4'd0,  3'd0, E_NEG, O_SAT, 1};
        vecs[3] = '{16'sd30000,  8'hFF, 3'd0, 1'b0, 4'd2,  3'd2, E_BIG, O_SAT, 4};
        vecs[4] = '{-16'sd5,     8'hFF, 3'd0, 1'b0, 4'd3,  3'd1, -10,   0,     8};
        vecs[5] = '{16'sd7,      8'hFF, 3'd0, 1'b0, 4'd15, 3'd0, 7,     0,     4096};
        vecs[6] = '{16'sd123,    8'h04, 3'd2, 1'b0, 4'd1,  3'd0, 123,   0,     2};
        vecs[7] = '{16'sd123,    8'h04, 3'd3, 1'b0, 4'd1,  3'd0, -123,  0,     2};
        vecs[8] = '{-16'sd1,     8'hFF, 3'd0, 1'b0, 4'd1,  3'd0, -1,    0,     2};
        vecs[9] = '{-16'sd3,     8'hFF, 3'd0, 1'b0, 4'd2,  3'd3, -24,   0,     4};

        adc_valid = 1'b1;
        repeat (3) tick();
        check("reset err", err, 0);
        check("reset err_valid", err_valid, 0);
        check("reset ovf", ovf, 0);
        sys_rst = 1'b0;
        adc_valid = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            adc = vecs[v].adc;
            pdh_ref = vecs[v].pref;
            ref_sel = vecs[v].sel;
            invert = vecs[v].inv;
            dec_log2 = vecs[v].dec;
            gain_log2 = vecs[v].gain;
            ref_delay = '0;
            clr = 1'b1;
            tick();
            clr = 1'b0;
            adc_valid = 1'b1;
            wait_strobe(vecs[v].n + 8, n);
            check($sformatf("vec%0d latency", v), n, vecs[v].n + 3);
            check($sformatf("vec%0d err", v), err, vecs[v].exp_err);
            check($sformatf("vec%0d ovf", v), ovf, vecs[v].exp_ovf);
            adc_valid = 1'b0;
        end

        // period between strobes at continuous valid
        adc = 16'sd1000; pdh_ref = 8'hFF; ref_sel = 0; invert = 0; dec_log2 = 4; gain_log2 = 0;
        clr = 1'b1; tick(); clr = 1'b0;
        adc_valid = 1'b1;
        wait_strobe(30, n);
        check("period first", n, 19);
        wait_strobe(30, n);
        check("period gap", n, 16);
        check("period err", err, 1000);

        // ovf stays set across later in-range windows until clr
        adc = 16'sd30000; dec_log2 = 2; gain_log2 = 2;
        clr = 1'b1; tick(); clr = 1'b0;
        wait_strobe(12, n);
        adc = 16'sd10;
        wait_strobe(12, n);
        wait_strobe(12, n);
        wait_strobe(12, n);
        check("sticky err", err, 40);
        check("sticky ovf", ovf, O_SAT);
        adc_valid = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr ovf", ovf, 0);
        check("clr holds err", err, 40);

        // reference toggling each cycle
        dec_log2 = 1; gain_log2 = 0; ref_sel = 0; invert = 0;
        tog_mode(1'b0, 4'd0, 0, "tog const");
        tog_mode(1'b1, 4'd0, 300, "tog inphase");
        tog_mode(1'b1, 4'd1, -300, "tog delay1");

        // clr aborts a partial window with no strobe for it
        pdh_ref = 8'hFF; adc = 16'sd100; dec_log2 = 4; ref_delay = 0;
        clr = 1'b1; tick(); clr = 1'b0;
        adc_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (err_valid) seen++;
        end
        clr = 1'b1; tick(); clr = 1'b0;
        if (err_valid) seen++;
        adc = 16'sd200;
        wait_strobe(30, n);
        check("abort strobes", seen, 0);
        check("abort latency", n, 19);
        check("abort err", err, 200);

        // reset mid-window
        adc = 16'sd1000;
        repeat (7) tick();
        sys_rst = 1'b1;
        tick();
        check("midrst err", err, 0);
        check("midrst err_valid", err_valid, 0);
        check("midrst ovf", ovf, 0);
        sys_rst = 1'b0;
        wait_strobe(30, n);
        check("postrst latency", n, 19);
        check("postrst err", err, 1000);
        adc_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
